// File: rtl/fnd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// conversion FSM state encoding and the nibble-to-segment lookup.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef logic [1:0] conv_state_t;

    localparam conv_state_t ST_IDLE  = 2'd0;
    localparam conv_state_t ST_SHIFT = 2'd1;
    localparam conv_state_t ST_DONE  = 2'd2;

    // Active-low {dp,g..a}; dp is left off here and forced by the caller.
    function automatic logic [7:0] seg_of_nibble(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per clock, DATA_W shift cycles, then a
// one-cycle DONE strobe. Digits above N_DIGITS are dropped and flagged as overflow.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int DATA_W   = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       value_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*N_DIGITS-1:0]   bcd_o,
    output logic                    ovf_o
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic [63:0] MAX_DEC = pow10(N_DIGITS) - 64'd1;

    conv_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              value_ovf;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign value_ovf = {{(64-DATA_W){1'b0}}, value_i} > MAX_DEC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bin_d   = value_i;
                    bcd_d   = '0;
                    ovf_d   = value_ovf;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
        ovf_q <= ovf_d;
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment driver: latches a value, converts it to BCD (or
// takes hex nibbles), and scans the digits with blanking, dots and blink.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int N_DIGITS  = 4,
    parameter int DATA_W    = 14,
    parameter int BLINK_DIV = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   i_value,
    input  logic                i_load,
    input  logic                i_hex,
    input  logic [N_DIGITS-1:0] i_dot_mask,
    input  logic                i_blank_lz,
    input  logic                i_blink_en,
    output logic [N_DIGITS-1:0] fnd_com,
    output logic [7:0]          fnd_data,
    output logic                o_busy,
    output logic                o_ovf
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = $clog2(N_DIGITS);
    localparam int BL_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int BCD_W    = 4 * N_DIGITS;

    logic [TICK_W-1:0]   tick_cnt_q;
    logic                tick;
    logic [IDX_W-1:0]    idx_q;
    logic [BL_W-1:0]     blink_cnt_q;
    logic                phase_q;

    logic                conv_busy, conv_done, conv_ovf, conv_start;
    logic [BCD_W-1:0]    conv_bcd;

    logic                pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]   pend_val_q, pend_val_d;
    logic                pend_hex_q, pend_hex_d;
    logic                take_pend, take_new, start_hex, hex_start;
    logic [DATA_W-1:0]   start_val;

    logic                hex_wr_q;
    logic [DATA_W-1:0]   hex_val_q;
    logic [31:0]         hex_ext;
    logic                hex_ovf;

    logic [BCD_W-1:0]    disp_q;
    logic                dovf_q;

    logic [3:0]          digit;
    logic                blank;
    logic [7:0]          data_d, data_q;
    logic [N_DIGITS-1:0] com_d, com_q;

    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // A waiting load always goes before a new strobe; the new one takes the slot.
    assign take_pend  = !conv_busy && pend_vld_q;
    assign take_new   = !conv_busy && !pend_vld_q && i_load;
    assign start_val  = pend_vld_q ? pend_val_q : i_value;
    assign start_hex  = pend_vld_q ? pend_hex_q : i_hex;
    assign conv_start = (take_pend || take_new) && !start_hex;
    assign hex_start  = (take_pend || take_new) && start_hex;

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        pend_hex_d = pend_hex_q;
        if (take_pend) pend_vld_d = 1'b0;
        if (i_load && !take_new) begin
            pend_vld_d = 1'b1;
            pend_val_d = i_value;
            pend_hex_d = i_hex;
        end
    end

    bin2bcd_seq #(
        .DATA_W   (DATA_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (conv_start),
        .value_i (start_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    assign hex_ext = {{(32-DATA_W){1'b0}}, hex_val_q};
    assign hex_ovf = |(hex_ext >> BCD_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld_q <= 1'b0;
            hex_wr_q   <= 1'b0;
            disp_q     <= '0;
            dovf_q     <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            hex_wr_q   <= hex_start;
            if (conv_done) begin
                disp_q <= conv_bcd;
                dovf_q <= conv_ovf;
            end else if (hex_wr_q) begin
                disp_q <= hex_ext[BCD_W-1:0];
                dovf_q <= hex_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        pend_val_q <= pend_val_d;
        pend_hex_q <= pend_hex_d;
        if (hex_start) hex_val_q <= start_val;
    end

    always_comb begin
        digit  = disp_q[{idx_q, 2'b00} +: 4];
        blank  = i_blank_lz && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
        data_d = dovf_q ? SEG_DASH : (blank ? SEG_BLANK : seg_of_nibble(digit));
        if (i_dot_mask[idx_q]) data_d[7] = 1'b0;
        com_d  = (i_blink_en && !phase_q) ? '1 : ~(N_DIGITS'(1) << idx_q);
    end

    // Enable and segment bits are registered together so they never skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            com_q  <= '1;
            data_q <= SEG_BLANK;
        end else begin
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;
    assign o_busy   = conv_busy;
    assign o_ovf    = dovf_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: table of loads with expected digit codes fed
// through a scoreboard queue, plus sequences for reset, back-to-back and blink.
module tb_fnd_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] i_value;
    logic        i_load, i_hex, i_blank_lz, i_blink_en;
    logic [3:0]  i_dot_mask;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic        o_busy, o_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [13:0] value;
        logic        hex;
        logic        blank;
        logic [3:0]  dot;
        logic [31:0] segs;
        logic        ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] segs;
        logic        ovf;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[14];

    fnd_scan_ctrl #(
        .CLK_HZ    (40),
        .SCAN_HZ   (10),
        .N_DIGITS  (4),
        .DATA_W    (14),
        .BLINK_DIV (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_value    (i_value),
        .i_load     (i_load),
        .i_hex      (i_hex),
        .i_dot_mask (i_dot_mask),
        .i_blank_lz (i_blank_lz),
        .i_blink_en (i_blink_en),
        .fnd_com    (fnd_com),
        .fnd_data   (fnd_data),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [31:0] segs, input logic ovf);
        sb_t e;
        e.name = name;
        e.segs = segs;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    task automatic capture(output logic [31:0] segs, output logic [3:0] seen);
        logic [3:0] sel;
        segs = '1;
        seen = '0;
        for (int c = 0; c < 64 && seen != 4'hF; c++) begin
            for (int k = 0; k < 4; k++) begin
                sel = 4'b0001 << k;
                if (fnd_com == ~sel) begin
                    segs[8*k +: 8] = fnd_data;
                    seen[k] = 1'b1;
                end
            end
            step();
        end
    endtask

    task automatic check_display();
        sb_t         e;
        logic [31:0] got;
        logic [3:0]  seen;
        capture(got, seen);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_seen"}, {28'd0, seen}, 32'hF);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_d%0d", e.name, k), {24'd0, got[8*k +: 8]}, {24'd0, e.segs[8*k +: 8]});
            chk({e.name, "_ovf"}, {31'd0, o_ovf}, {31'd0, e.ovf});
        end
    endtask

    task automatic apply_load(input string name, input vec_t v);
        int bc;
        i_blank_lz = v.blank;
        i_dot_mask = v.dot;
        i_value    = v.value;
        i_hex      = v.hex;
        i_load     = 1'b1;
        push_exp(name, v.segs, v.ovf);
        step();
        i_load = 1'b0;
        bc = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_busy) bc++;
            step();
        end
        chk({name, "_busy_cycles"}, bc, v.hex ? 32'd0 : 32'd15);
        check_display();
    endtask

    task automatic pulse_load(input logic [13:0] v);
        i_value = v;
        i_hex   = 1'b0;
        i_load  = 1'b1;
        step();
        i_load  = 1'b0;
    endtask

    initial begin
        int  bc, rises, ones, bad, run, max_run, trans, prev, cur, runlen, run_err;
        logic prev_busy;
        logic [3:0] sel;

        vecs[0]  = '{14'd1234,  1'b0, 1'b0, 4'b0000, 32'hF9A4B099, 1'b0};
        vecs[1]  = '{14'd7,     1'b0, 1'b1, 4'b0000, 32'hFFFFFFF8, 1'b0};
        vecs[2]  = '{14'd0,     1'b0, 1'b1, 4'b0000, 32'hFFFFFFC0, 1'b0};
        vecs[3]  = '{14'd12000, 1'b0, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b1};
        vecs[4]  = '{14'h03AF,  1'b1, 1'b0, 4'b0000, 32'hC0B0888E, 1'b0};
        vecs[5]  = '{14'd9999,  1'b0, 1'b0, 4'b0000, 32'h90909090, 1'b0};
        vecs[6]  = '{14'd10000, 1'b0, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b1};
        vecs[7]  = '{14'h1ABC,  1'b1, 1'b0, 4'b0000, 32'hF98883C6, 1'b0};
        vecs[8]  = '{14'd0,     1'b0, 1'b0, 4'b0000, 32'hC0C0C0C0, 1'b0};
        vecs[9]  = '{14'd50,    1'b0, 1'b1, 4'b0010, 32'hFFFF12C0, 1'b0};
        vecs[10] = '{14'd7,     1'b0, 1'b1, 4'b1000, 32'h7FFFFFF8, 1'b0};
        vecs[11] = '{14'h0005,  1'b1, 1'b1, 4'b0000, 32'hFFFFFF92, 1'b0};
        vecs[12] = '{14'd4095,  1'b0, 1'b0, 4'b0000, 32'h99C09092, 1'b0};
        vecs[13] = '{14'd100,   1'b0, 1'b1, 4'b0000, 32'hFFF9C0C0, 1'b0};

        reset = 1'b1; i_value = '0; i_load = 1'b0; i_hex = 1'b0;
        i_dot_mask = '0; i_blank_lz = 1'b0; i_blink_en = 1'b0;
        repeat (3) step();
        chk("rst_com",  {28'd0, fnd_com}, 32'hF);
        chk("rst_data", {24'd0, fnd_data}, 32'hFF);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_ovf",  {31'd0, o_ovf}, 32'd0);
        reset = 1'b0;
        step();
        chk("first_com",  {28'd0, fnd_com}, 32'hE);
        chk("first_data", {24'd0, fnd_data}, 32'hC0);
        push_exp("rst_disp", 32'hC0C0C0C0, 1'b0);
        check_display();

        // Reset in the middle of a conversion discards it.
        pulse_load(14'd999);
        repeat (5) step();
        chk("abort_busy_pre", {31'd0, o_busy}, 32'd1);
        reset = 1'b1;
        step();
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_com",  {28'd0, fnd_com}, 32'hF);
        reset = 1'b0;
        bc = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_busy) bc++;
            step();
        end
        chk("abort_no_busy", bc, 32'd0);
        push_exp("abort_disp", 32'hC0C0C0C0, 1'b0);
        check_display();

        // Digit scan order and dwell time.
        trans = 0; run_err = 0; prev = -1; runlen = 0;
        for (int c = 0; c < 48; c++) begin
            cur = -1;
            for (int k = 0; k < 4; k++) begin
                sel = 4'b0001 << k;
                if (fnd_com == ~sel) cur = k;
            end
            if (cur < 0) run_err++;
            else if (prev >= 0 && cur != prev) begin
                if (cur != (prev + 1) % 4) run_err++;
                if (trans > 0 && runlen != DIV) run_err++;
                trans++;
                runlen = 0;
            end
            prev = cur;
            runlen++;
            step();
        end
        chk("scan_order_errors", run_err, 32'd0);
        chk("scan_transitions_ge8", {31'd0, trans >= 8}, 32'd1);

        for (int i = 0; i < 14; i++) apply_load($sformatf("vec%0d", i), vecs[i]);

        // Loads while busy: the newest overwrites the pending slot.
        i_blank_lz = 1'b0; i_dot_mask = '0;
        push_exp("b2b", 32'hC0C0B0B0, 1'b0);
        rises = 0; prev_busy = o_busy;
        i_value = 14'd11; i_hex = 1'b0; i_load = 1'b1;
        for (int c = 0; c < 70; c++) begin
            step();
            i_load = 1'b0;
            if (c == 2) begin i_value = 14'd22; i_load = 1'b1; end
            if (c == 4) begin i_value = 14'd33; i_load = 1'b1; end
            if (o_busy && !prev_busy) rises++;
            prev_busy = o_busy;
        end
        i_load = 1'b0;
        chk("b2b_conversions", rises, 32'd2);
        check_display();

        // Blink: all-ones for half of every 4-tick period.
        i_blink_en = 1'b1;
        repeat (2) step();
        ones = 0; bad = 0; run = 0; max_run = 0;
        for (int c = 0; c < 64; c++) begin
            if (fnd_com == 4'hF) begin
                ones++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
                if (!(fnd_com == 4'hE || fnd_com == 4'hD || fnd_com == 4'hB || fnd_com == 4'h7)) bad++;
            end
            step();
        end
        chk("blink_off_cycles", ones, 32'd32);
        chk("blink_max_run", max_run, 32'd8);
        chk("blink_bad_com", bad, 32'd0);
        i_blink_en = 1'b0;
        repeat (2) step();
        ones = 0;
        for (int c = 0; c < 32; c++) begin
            if (fnd_com == 4'hF) ones++;
            step();
        end
        chk("noblink_off_cycles", ones, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
